// File: rtl/sram_port0_ctrl.sv
// Request/response initiator for the RW port of the 32x512 OpenRAM macro.
// Registers every macro input, optionally zero-fills the array after reset, and returns one response per request.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_WMASKS    = 4,
  parameter int ADDR_WIDTH    = 9,
  parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0]            RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  init_done_q, init_done_d;

  // last_q marks that the final fill address is already on the macro pins,
  // so the counter never needs an extra bit to reach RAM_DEPTH.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    csb_d       = csb_q;
    web_d       = web_q;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;

    case (state_q)
      S_INIT: begin
        if (last_q) begin
          csb_d       = 1'b1;
          web_d       = 1'b1;
          init_done_d = 1'b1;
          last_d      = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = '1;
          addr_d  = cnt_q;
          din_d   = INIT_VALUE;
          cnt_d   = cnt_q + 1'b1;
          last_d  = (cnt_q == LAST_ADDR);
        end
      end
      S_IDLE: begin
        csb_d       = 1'b1;
        init_done_d = 1'b1;
        if (req_valid) begin
          csb_d    = 1'b0;
          web_d    = ~req_we;
          addr_d   = req_addr;
          din_d    = req_wdata;
          wmask_d  = req_we ? req_wmask : '0;
          rsp_we_d = req_we;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        state_d = S_WAIT;
      end
      // The macro read at the negedge after ISSUE, so dout0 is valid here.
      S_WAIT: begin
        rsp_rdata_d = rsp_we_q ? '0 : sram_dout0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_we      = rsp_we_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign init_done   = init_done_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule
